// File: rtl/bp_cce_pkg.sv
// Shared CCE types: coherence states, the gather-directory FSM state and the packed result record.
// Processor configuration (LCE count, way and LCE-id widths) is carried here as the default cfg.
package bp_cce_pkg;

    localparam int num_lce_gp         = 4;
    localparam int lce_assoc_width_gp = 3;
    localparam int lce_id_width_gp    = 3;
    localparam int coh_width_gp       = 3;

    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    typedef enum logic [1:0] {
        e_gad_idle    = 2'd0,
        e_gad_collect = 2'd1,
        e_gad_done    = 2'd2
    } bp_cce_gad_state_e;

    typedef struct packed {
        logic [lce_assoc_width_gp-1:0] req_addr_way;
        logic [lce_id_width_gp-1:0]    owner_lce;
        logic [lce_assoc_width_gp-1:0] owner_way;
        bp_coh_states_e                owner_coh_state;
        logic                          replacement;
        logic                          upgrade;
        logic                          cached_shared;
        logic                          cached_exclusive;
        logic                          cached_modified;
        logic                          cached_owned;
        logic                          cached_forward;
    } bp_cce_gad_result_s;

    // E/M/O/F are the states that make an LCE the block's owner.
    function automatic logic is_owner_state(input bp_coh_states_e st);
        return (st == e_COH_E) || (st == e_COH_M) || (st == e_COH_O) || (st == e_COH_F);
    endfunction

endpackage

// File: rtl/bp_cce_gad_beat_reduce.sv
// Combinational reduction of one directory beat: cached-other flags, requester match and lowest-index owner.
// Macro BP_CCE_GAD_OWNER_CHECK_EN adds a flag for more than one owner candidate within the beat.
module bp_cce_gad_beat_reduce
    import bp_cce_pkg::*;
#(
    parameter int lces_per_beat_p = 2,
    parameter int beat_width_p    = 1
) (
    input  logic [beat_width_p-1:0]                       beat,
    input  logic [lce_id_width_gp-1:0]                    req_lce,
    input  logic [lces_per_beat_p-1:0]                    hits,
    input  logic [lces_per_beat_p*lce_assoc_width_gp-1:0] ways,
    input  logic [lces_per_beat_p*coh_width_gp-1:0]       states,
    output logic                                          other_s,
    output logic                                          other_e,
    output logic                                          other_m,
    output logic                                          other_o,
    output logic                                          other_f,
    output logic                                          req_hit,
    output logic [lce_assoc_width_gp-1:0]                 req_way,
    output bp_coh_states_e                                req_state,
    output logic                                          own_v,
    output logic [lce_id_width_gp-1:0]                    own_lce,
    output logic [lce_assoc_width_gp-1:0]                 own_way,
    output bp_coh_states_e                                own_state
`ifdef BP_CCE_GAD_OWNER_CHECK_EN
    ,
    output logic                                          own_multi
`endif
);

    logic [lces_per_beat_p-1:0]    in_range;
    logic [lces_per_beat_p-1:0]    is_req;
    logic [lces_per_beat_p-1:0]    other;
    logic [lces_per_beat_p-1:0]    own_hit;
    logic [lce_id_width_gp-1:0]    entry_lce   [lces_per_beat_p];
    logic [lce_assoc_width_gp-1:0] entry_way   [lces_per_beat_p];
    bp_coh_states_e                entry_state [lces_per_beat_p];

    genvar gi;
    generate
        for (gi = 0; gi < lces_per_beat_p; gi++) begin : g_entry
            logic [31:0] idx;
            assign idx             = 32'(beat) * 32'(lces_per_beat_p) + 32'(gi);
            // Padding entries past the last LCE never match anything.
            assign in_range[gi]    = idx < 32'(num_lce_gp);
            assign is_req[gi]      = in_range[gi] & (idx == 32'(req_lce));
            assign entry_lce[gi]   = idx[lce_id_width_gp-1:0];
            assign entry_way[gi]   = ways[gi*lce_assoc_width_gp +: lce_assoc_width_gp];
            assign entry_state[gi] = bp_coh_states_e'(states[gi*coh_width_gp +: coh_width_gp]);
            assign other[gi]       = hits[gi] & in_range[gi] & ~is_req[gi];
            assign own_hit[gi]     = hits[gi] & in_range[gi] & is_owner_state(entry_state[gi]);
        end
    endgenerate

    always_comb begin
        other_s   = 1'b0;
        other_e   = 1'b0;
        other_m   = 1'b0;
        other_o   = 1'b0;
        other_f   = 1'b0;
        req_hit   = 1'b0;
        req_way   = '0;
        req_state = e_COH_I;
        for (int j = 0; j < lces_per_beat_p; j++) begin
            if (other[j]) begin
                case (entry_state[j])
                    e_COH_S: other_s = 1'b1;
                    e_COH_E: other_e = 1'b1;
                    e_COH_M: other_m = 1'b1;
                    e_COH_O: other_o = 1'b1;
                    e_COH_F: other_f = 1'b1;
                    default: ;
                endcase
            end
            if (is_req[j] && hits[j]) begin
                req_hit   = 1'b1;
                req_way   = entry_way[j];
                req_state = entry_state[j];
            end
        end
    end

    // Scan from the top so the lowest-index candidate is the one left standing.
    always_comb begin
        own_v     = 1'b0;
        own_lce   = '0;
        own_way   = '0;
        own_state = e_COH_I;
        for (int j = lces_per_beat_p - 1; j >= 0; j--) begin
            if (own_hit[j]) begin
                own_v     = 1'b1;
                own_lce   = entry_lce[j];
                own_way   = entry_way[j];
                own_state = entry_state[j];
            end
        end
    end

`ifdef BP_CCE_GAD_OWNER_CHECK_EN
    assign own_multi = |(own_hit & (own_hit - lces_per_beat_p'(1)));
`endif

endmodule

// File: rtl/bp_cce_gad_pipe.sv
// Multi-beat gather of directory entries into registered owner/way/coherence flags behind valid/yumi.
// Macro BP_CCE_GAD_OWNER_CHECK_EN enables the sticky multiple-owner conflict output.
module bp_cce_gad_pipe
    import bp_cce_pkg::*;
#(
    parameter int lces_per_beat_p = 2
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          start_v_i,
    output logic                                          start_ready_o,
    input  logic [lce_id_width_gp-1:0]                    req_lce_i,
    input  logic                                          req_type_flag_i,
    input  logic [coh_width_gp-1:0]                       lru_coh_state_i,
    input  logic                                          atomic_req_flag_i,
    input  logic                                          uncached_req_flag_i,
    input  logic                                          dir_v_i,
    output logic                                          dir_ready_o,
    input  logic [lces_per_beat_p-1:0]                    dir_hits_i,
    input  logic [lces_per_beat_p*lce_assoc_width_gp-1:0] dir_ways_i,
    input  logic [lces_per_beat_p*coh_width_gp-1:0]       dir_coh_states_i,
    output logic                                          v_o,
    input  logic                                          yumi_i,
    output logic [lce_assoc_width_gp-1:0]                 req_addr_way_o,
    output logic [lce_id_width_gp-1:0]                    owner_lce_o,
    output logic [lce_assoc_width_gp-1:0]                 owner_way_o,
    output logic [coh_width_gp-1:0]                       owner_coh_state_o,
    output logic                                          replacement_flag_o,
    output logic                                          upgrade_flag_o,
    output logic                                          cached_shared_flag_o,
    output logic                                          cached_exclusive_flag_o,
    output logic                                          cached_modified_flag_o,
    output logic                                          cached_owned_flag_o,
    output logic                                          cached_forward_flag_o,
    output logic                                          owner_conflict_o
);

    localparam int num_beats_lp = (num_lce_gp + lces_per_beat_p - 1) / lces_per_beat_p;
    localparam int cnt_width_lp = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(num_beats_lp - 1);

    bp_cce_gad_state_e state_reg, state_next;
    logic [cnt_width_lp-1:0] cnt_reg;

    logic [lce_id_width_gp-1:0] req_lce_reg;
    logic req_type_reg, atomic_reg, uncached_reg;
    bp_coh_states_e lru_reg;

    logic acc_s_reg, acc_e_reg, acc_m_reg, acc_o_reg, acc_f_reg;
    logic acc_s_next, acc_e_next, acc_m_next, acc_o_next, acc_f_next;
    logic req_hit_reg, req_hit_next;
    logic [lce_assoc_width_gp-1:0] req_way_reg, req_way_next;
    bp_coh_states_e req_state_reg, req_state_next;
    logic own_v_reg, own_v_next;
    logic [lce_id_width_gp-1:0] own_lce_reg, own_lce_next;
    logic [lce_assoc_width_gp-1:0] own_way_reg, own_way_next;
    bp_coh_states_e own_state_reg, own_state_next;

    bp_cce_gad_result_s result_reg, result_next;
    logic upgrade_next;

    logic start_accept, beat_accept, last_beat;
    logic [lces_per_beat_p-1:0] hits_gated;

    logic b_s, b_e, b_m, b_o, b_f, b_req_hit, b_own_v;
    logic [lce_assoc_width_gp-1:0] b_req_way, b_own_way;
    logic [lce_id_width_gp-1:0] b_own_lce;
    bp_coh_states_e b_req_state, b_own_state;

    assign start_accept = start_v_i & start_ready_o;
    assign beat_accept  = dir_v_i & dir_ready_o;
    assign last_beat    = beat_accept & (cnt_reg == last_beat_lp);
    // Gating hits means the reduction contributes nothing unless a beat is actually taken.
    assign hits_gated   = dir_hits_i & {lces_per_beat_p{beat_accept}};

`ifdef BP_CCE_GAD_OWNER_CHECK_EN
    logic b_own_multi;
    logic conflict_reg;
`endif

    bp_cce_gad_beat_reduce #(
        .lces_per_beat_p(lces_per_beat_p),
        .beat_width_p   (cnt_width_lp)
    ) reduce (
        .beat     (cnt_reg),
        .req_lce  (req_lce_reg),
        .hits     (hits_gated),
        .ways     (dir_ways_i),
        .states   (dir_coh_states_i),
        .other_s  (b_s),
        .other_e  (b_e),
        .other_m  (b_m),
        .other_o  (b_o),
        .other_f  (b_f),
        .req_hit  (b_req_hit),
        .req_way  (b_req_way),
        .req_state(b_req_state),
        .own_v    (b_own_v),
        .own_lce  (b_own_lce),
        .own_way  (b_own_way),
        .own_state(b_own_state)
`ifdef BP_CCE_GAD_OWNER_CHECK_EN
        ,
        .own_multi(b_own_multi)
`endif
    );

    always_comb begin
        state_next    = state_reg;
        start_ready_o = 1'b0;
        dir_ready_o   = 1'b0;
        v_o           = 1'b0;
        case (state_reg)
            e_gad_idle: begin
                start_ready_o = 1'b1;
                if (start_v_i) state_next = e_gad_collect;
            end
            e_gad_collect: begin
                dir_ready_o = 1'b1;
                if (dir_v_i && (cnt_reg == last_beat_lp)) state_next = e_gad_done;
            end
            e_gad_done: begin
                v_o = 1'b1;
                if (yumi_i) state_next = e_gad_idle;
            end
            default: state_next = e_gad_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_reg <= e_gad_idle;
        else         state_reg <= state_next;
    end

    // Final flags are formed from the accumulators merged with the beat being accepted.
    always_comb begin
        acc_s_next     = acc_s_reg | b_s;
        acc_e_next     = acc_e_reg | b_e;
        acc_m_next     = acc_m_reg | b_m;
        acc_o_next     = acc_o_reg | b_o;
        acc_f_next     = acc_f_reg | b_f;
        req_hit_next   = req_hit_reg | b_req_hit;
        req_way_next   = b_req_hit ? b_req_way : req_way_reg;
        req_state_next = b_req_hit ? b_req_state : req_state_reg;
        own_v_next     = own_v_reg | b_own_v;
        own_lce_next   = own_lce_reg;
        own_way_next   = own_way_reg;
        own_state_next = own_state_reg;
        if (!own_v_reg && b_own_v) begin
            own_lce_next   = b_own_lce;
            own_way_next   = b_own_way;
            own_state_next = b_own_state;
        end

        upgrade_next = req_type_reg & req_hit_next
                     & ((req_state_next == e_COH_S) || (req_state_next == e_COH_F)
                        || (req_state_next == e_COH_O));

        result_next                  = '0;
        result_next.req_addr_way     = req_hit_next ? req_way_next : '0;
        result_next.owner_lce        = own_v_next ? own_lce_next : '0;
        result_next.owner_way        = own_v_next ? own_way_next : '0;
        result_next.owner_coh_state  = own_v_next ? own_state_next : e_COH_I;
        result_next.upgrade          = upgrade_next;
        result_next.replacement      = (~upgrade_next & ((lru_reg == e_COH_E) || (lru_reg == e_COH_M)
                                                         || (lru_reg == e_COH_O)))
                                     | (req_hit_next & (atomic_reg | uncached_reg));
        result_next.cached_shared    = acc_s_next;
        result_next.cached_exclusive = acc_e_next;
        result_next.cached_modified  = acc_m_next;
        result_next.cached_owned     = acc_o_next;
        result_next.cached_forward   = acc_f_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_reg       <= '0;
            req_lce_reg   <= '0;
            req_type_reg  <= 1'b0;
            atomic_reg    <= 1'b0;
            uncached_reg  <= 1'b0;
            lru_reg       <= e_COH_I;
            acc_s_reg     <= 1'b0;
            acc_e_reg     <= 1'b0;
            acc_m_reg     <= 1'b0;
            acc_o_reg     <= 1'b0;
            acc_f_reg     <= 1'b0;
            req_hit_reg   <= 1'b0;
            req_way_reg   <= '0;
            req_state_reg <= e_COH_I;
            own_v_reg     <= 1'b0;
            own_lce_reg   <= '0;
            own_way_reg   <= '0;
            own_state_reg <= e_COH_I;
            result_reg    <= '0;
        end else if (start_accept) begin
            cnt_reg       <= '0;
            req_lce_reg   <= req_lce_i;
            req_type_reg  <= req_type_flag_i;
            atomic_reg    <= atomic_req_flag_i;
            uncached_reg  <= uncached_req_flag_i;
            lru_reg       <= bp_coh_states_e'(lru_coh_state_i);
            acc_s_reg     <= 1'b0;
            acc_e_reg     <= 1'b0;
            acc_m_reg     <= 1'b0;
            acc_o_reg     <= 1'b0;
            acc_f_reg     <= 1'b0;
            req_hit_reg   <= 1'b0;
            req_way_reg   <= '0;
            req_state_reg <= e_COH_I;
            own_v_reg     <= 1'b0;
            own_lce_reg   <= '0;
            own_way_reg   <= '0;
            own_state_reg <= e_COH_I;
            result_reg    <= '0;
        end else if (beat_accept) begin
            acc_s_reg     <= acc_s_next;
            acc_e_reg     <= acc_e_next;
            acc_m_reg     <= acc_m_next;
            acc_o_reg     <= acc_o_next;
            acc_f_reg     <= acc_f_next;
            req_hit_reg   <= req_hit_next;
            req_way_reg   <= req_way_next;
            req_state_reg <= req_state_next;
            own_v_reg     <= own_v_next;
            own_lce_reg   <= own_lce_next;
            own_way_reg   <= own_way_next;
            own_state_reg <= own_state_next;
            if (last_beat) result_reg <= result_next;
            else           cnt_reg    <= cnt_reg + cnt_width_lp'(1);
        end
    end

`ifdef BP_CCE_GAD_OWNER_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (reset_i || start_accept) conflict_reg <= 1'b0;
        else if (beat_accept)        conflict_reg <= conflict_reg | (own_v_reg & b_own_v) | b_own_multi;
    end
    assign owner_conflict_o = conflict_reg & (state_reg == e_gad_done);
`else
    assign owner_conflict_o = 1'b0;
`endif

    assign req_addr_way_o          = result_reg.req_addr_way;
    assign owner_lce_o             = result_reg.owner_lce;
    assign owner_way_o             = result_reg.owner_way;
    assign owner_coh_state_o       = result_reg.owner_coh_state;
    assign replacement_flag_o      = result_reg.replacement;
    assign upgrade_flag_o          = result_reg.upgrade;
    assign cached_shared_flag_o    = result_reg.cached_shared;
    assign cached_exclusive_flag_o = result_reg.cached_exclusive;
    assign cached_modified_flag_o  = result_reg.cached_modified;
    assign cached_owned_flag_o     = result_reg.cached_owned;
    assign cached_forward_flag_o   = result_reg.cached_forward;

endmodule

// File: doc/bp_cce_gad_pipe.md
# bp_cce_gad_pipe

Multi-beat, handshaked successor to the CCE auxiliary-directory-information unit. Accepts one request context, accumulates directory way-group entries streamed from the directory RAM `lces_per_beat_p` LCEs per beat, and produces registered owner, way and coherence flag outputs behind a valid/yumi handshake. Sits between the directory read port and the CCE instruction/flag logic, so a wide LCE count never needs a single-cycle full-directory reduction.

## Interface

Parameters:

- `bp_params_p`, `e_bp_default_cfg`: processor configuration; supplies `num_lce_p`, `lce_assoc_width_p`, `lce_id_width_p`.
- `lces_per_beat_p`, 2: directory entries delivered per beat.
  - Legal range is 1..`num_lce_p`.
  - Derived: `num_beats_lp` = ceil(`num_lce_p`/`lces_per_beat_p`).

Ports:

- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_v_i`  in  1  request context valid.
- `start_ready_o`  out  1  high only in IDLE; a start is accepted when `start_v_i & start_ready_o`.
- `req_lce_i`  in  `lce_id_width_p`  requesting LCE.
- `req_type_flag_i`  in  1  1 = store/write request.
- `lru_coh_state_i`  in  `bp_coh_states_e`  state of the LRU victim.
- `atomic_req_flag_i`, `uncached_req_flag_i`  in  1 each  request attributes.
- `dir_v_i`  in  1  directory beat valid.
- `dir_ready_o`  out  1  high only in COLLECT.
- `dir_hits_i`  in  `lces_per_beat_p`  per-entry hit.
- `dir_ways_i`  in  `lces_per_beat_p` x `lce_assoc_width_p`  per-entry way.
- `dir_coh_states_i`  in  `lces_per_beat_p` x `bp_coh_states_e`  per-entry state.
- `v_o`  out  1  results valid.
- `yumi_i`  in  1  consumer takes results; legal only while `v_o`.
- `req_addr_way_o`  out  `lce_assoc_width_p`  way of the requester's hit.
- `owner_lce_o`  out  `lce_id_width_p`  owner LCE.
- `owner_way_o`  out  `lce_assoc_width_p`  owner way.
- `owner_coh_state_o`  out  `bp_coh_states_e`  owner state.
- `replacement_flag_o`, `upgrade_flag_o`  out  1 each.
- `cached_shared_flag_o`, `cached_exclusive_flag_o`, `cached_modified_flag_o`, `cached_owned_flag_o`, `cached_forward_flag_o`  out  1 each.
- `owner_conflict_o`  out  1  more than one LCE holds an owner state (see Configuration).

## Operation

FSM states: IDLE, COLLECT, DONE.

- **IDLE**
  - On start acceptance, latch the request context and clear all accumulators and outputs to their reset values.
  - Clear the beat counter to 0, then go to COLLECT.
- **COLLECT**
  - Beat b, entry j maps to LCE index b*`lces_per_beat_p`+j. Entries with index ≥ `num_lce_p` (padding in the last beat) are ignored.
  - Per valid entry:
    - OR a hit in S/E/M/O/F into the corresponding cached-other accumulator, excluding the requester's index.
    - When the index equals the requester, capture requester hit, way and state.
    - On a hit in E/M/O/F with no owner yet captured, capture the LCE index, way and state as owner. The lowest index wins.
  - Beats accepted while `dir_v_i & dir_ready_o`; the counter increments per beat.
  - On the beat with counter = `num_beats_lp`-1, register the final flags and go to DONE.
- **DONE**
  - `v_o` = 1. Outputs held stable until `yumi_i`, then go to IDLE.
  - Start is not accepted in DONE; there is no same-cycle yumi→start bypass.
- **Flag rules**, all evaluated on the accumulated data:
  - `upgrade` = `req_type` & requester hit in S, F or O.
  - `replacement` = (~`upgrade` & `lru` ∈ {E,M,O}) | (requester hit & (`atomic` | `uncached`)).
  - `req_addr_way_o` = captured way if requester hit, else 0.
  - Owner outputs are 0 / `e_COH_I` if no owner was found.
  - If `req_lce_i` ≥ `num_lce_p`, there is no requester match and all LCEs count as "other".
- **Reset**
  - All outputs 0, `owner_coh_state_o` = `e_COH_I`, state IDLE.
  - Reset mid-COLLECT or mid-DONE discards all partial data.

## Timing

- Start accept → first beat can be taken the next cycle.
- Last beat accepted in cycle N → `v_o` = 1 in cycle N+1, with registered outputs.
- Minimum occupancy is `num_beats_lp`+2 cycles per transaction.
- Gaps in `dir_v_i` stall COLLECT indefinitely without losing state.
- `dir_v_i` outside COLLECT is ignored.
- The beat counter is `BSG_SAFE_CLOG2(num_beats_lp)` bits wide and never wraps within a transaction.

## Configuration

Macro: `BP_CCE_GAD_OWNER_CHECK_EN`.

- **Defined:** a second E/M/O/F hit, after an owner was captured, sets a sticky conflict bit. It is presented on `owner_conflict_o` in DONE and cleared on start acceptance.
- **Undefined:** `owner_conflict_o` is tied to 0 and no conflict logic is built. Owner selection (lowest index) is identical in both builds.

## Structure

- Shared package `bp_cce_pkg` gets:
  - `bp_cce_gad_state_e` for IDLE/COLLECT/DONE;
  - a packed results struct `bp_cce_gad_result_s` for the way, owner and flag fields.
- One sub-module: `bp_cce_gad_beat_reduce`. It is the combinational per-beat reduction of hits, states and owner candidate, with the requester match, for `lces_per_beat_p` entries at a base index.

## Test plan

Bench configuration: `num_lce_p`=4, `lces_per_beat_p`=2, so 2 beats.

1. **Reset:** hold `reset_i` 2 cycles. Expect all outputs 0, `owner_coh_state_o`=`e_COH_I`, `start_ready_o`=1, `dir_ready_o`=0.
2. **Upgrade:** requester 1, store, LCE1 S way 2, `lru`=M, others invalid. Expect `upgrade`=1, `replacement`=0, `req_addr_way_o`=2, all cached-other flags 0.
3. **Owner in second beat:** requester 0, load, `lru`=I, LCE2 M way 3. Expect `owner_lce_o`=2, `owner_way_o`=3, `owner_coh_state_o`=M, `cached_modified`=1, and `v_o` exactly 1 cycle after beat 2.
4. **Two owners:** LCE1 E way 0, LCE3 F way 1. Expect `owner_lce_o`=1 and `owner_way_o`=0.
   - Macro defined: `owner_conflict_o`=1.
   - Macro undefined: `owner_conflict_o`=0.
5. **Backpressure:** `yumi_i` low 3 cycles, plus a 2-cycle `dir_v_i` gap between beats. Expect outputs stable while `v_o` is high, `start_ready_o`=0 throughout, and correct results.
6. **Reset mid-collect:** assert reset after beat 1, where LCE0 is M, then run a clean transaction with all entries invalid. Expect owner outputs 0/I and all flags 0.
